// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer carrying data plus a last flag with valid/ready on both sides.
// The head entry drives the master side directly from registers.
module axis_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            level
);

    logic [DATA_WIDTH-1:0] head_data, head_data_n;
    logic [DATA_WIDTH-1:0] tail_data, tail_data_n;
    logic                  head_last, head_last_n;
    logic                  tail_last, tail_last_n;
    logic [1:0]            count, count_n;
    logic                  push_c;
    logic                  pop_c;

    assign push_c  = s_valid & s_ready;
    assign pop_c   = m_valid & m_ready;
    assign m_data  = head_data;
    assign m_last  = head_last;
    assign level   = count;

    // Next occupancy and entry contents from push/pop
    always_comb begin
        head_data_n = head_data;
        head_last_n = head_last;
        tail_data_n = tail_data;
        tail_last_n = tail_last;
        count_n     = count;
        case (count)
            2'd0: begin
                if (push_c) begin
                    head_data_n = s_data;
                    head_last_n = s_last;
                    count_n     = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_data_n = s_data;
                    head_last_n = s_last;
                end else if (push_c) begin
                    tail_data_n = s_data;
                    tail_last_n = s_last;
                    count_n     = 2'd2;
                end else if (pop_c) begin
                    count_n     = 2'd0;
                end
            end
            2'd2: begin
                if (pop_c) begin
                    head_data_n = tail_data;
                    head_last_n = tail_last;
                    count_n     = 2'd1;
                end
            end
            default: count_n = 2'd0;
        endcase
    end

    // Entry registers and registered handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            count     <= 2'd0;
            m_valid   <= 1'b0;
            s_ready   <= 1'b1;
        end else begin
            head_data <= head_data_n;
            head_last <= head_last_n;
            tail_data <= tail_data_n;
            tail_last <= tail_last_n;
            count     <= count_n;
            m_valid   <= (count_n != 2'd0);
            s_ready   <= (count_n != 2'd2);
        end
    end

endmodule

// File: rtl/axis_bram_reader.sv
// Streams BRAM words 0..L out over AXI-Stream, one-shot or continuously until stopped.
// Reads are only issued when the skid buffer is guaranteed room for the returning word,
// which hides the one-cycle BRAM latency without bubbles.
module axis_bram_reader #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned BRAM_DATA_WIDTH  = 32,
    parameter int unsigned BRAM_ADDR_WIDTH  = 10,
    parameter string       CONTINUOUS       = "FALSE"
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    output logic                        sts_busy,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        bram_portb_clk,
    output logic                        bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata
);

    localparam bit CONT = (CONTINUOUS == "TRUE");

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                      state, state_n;
    logic [BRAM_ADDR_WIDTH-1:0]  addr, addr_n;
    logic [BRAM_ADDR_WIDTH-1:0]  last_addr, last_addr_n;
    logic [BRAM_ADDR_WIDTH-1:0]  cnt, cnt_n;
    logic                        stop_flag, stop_n;
    logic                        pend, pend_n;
    logic                        pend_last, pend_last_n;
    logic                        busy_n;

    logic                        sk_s_ready;
    logic                        sk_m_valid;
    logic                        sk_m_last;
    logic [1:0]                  sk_level;

    logic                        pop_c;
    logic                        room_c;
    logic                        issue_c;
    logic                        at_last_c;
    logic                        final_xfer_c;

    assign bram_portb_clk  = aclk;
    assign bram_portb_rst  = areset;
    assign bram_portb_addr = addr;
    assign sts_data        = cnt;
    assign m_axis_tvalid   = sk_m_valid;
    assign m_axis_tlast    = sk_m_last;

    assign pop_c        = sk_m_valid & m_axis_tready;
    // Words held plus the one in flight must leave a slot for the read issued now
    assign room_c       = (3'(sk_level) + 3'(pend)) < (3'd2 + 3'(pop_c));
    assign issue_c      = (state == RUN) && room_c;
    assign at_last_c    = (addr == last_addr);
    // Only the very last outstanding word ends the drain (guards single-word passes)
    assign final_xfer_c = pop_c && sk_m_last && (sk_level == 2'd1) && !pend;

    // Next-state, read issue, stop flag and transfer counter
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        last_addr_n = last_addr;
        stop_n      = stop_flag;
        pend_n      = pend & ~sk_s_ready;
        pend_last_n = pend_last;
        cnt_n       = cnt;

        if (pop_c) begin
            cnt_n = sk_m_last ? '0 : cnt + BRAM_ADDR_WIDTH'(1);
        end

        if (issue_c) begin
            pend_n      = 1'b1;
            pend_last_n = at_last_c;
        end

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_n     = RUN;
                    last_addr_n = cfg_data;
                    addr_n      = '0;
                    stop_n      = cfg_stop;
                    cnt_n       = '0;
                end
            end
            RUN: begin
                if (cfg_stop) begin
                    stop_n = 1'b1;
                end
                if (issue_c) begin
                    if (at_last_c) begin
                        addr_n = '0;
                        if (!CONT || stop_flag || cfg_stop) begin
                            state_n = DRAIN;
                        end
                    end else begin
                        addr_n = addr + BRAM_ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (final_xfer_c) begin
                    state_n = IDLE;
                    stop_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // Control registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            cnt       <= '0;
            stop_flag <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            sts_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            last_addr <= last_addr_n;
            cnt       <= cnt_n;
            stop_flag <= stop_n;
            pend      <= pend_n;
            pend_last <= pend_last_n;
            sts_busy  <= busy_n;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_data  (AXIS_TDATA_WIDTH'(bram_portb_rddata)),
        .s_last  (pend_last),
        .s_valid (pend),
        .s_ready (sk_s_ready),
        .m_data  (m_axis_tdata),
        .m_last  (sk_m_last),
        .m_valid (sk_m_valid),
        .m_ready (m_axis_tready),
        .level   (sk_level)
    );

endmodule

// File: doc/axis_bram_reader.md
AXIS_BRAM_READER -- requirements
Module: axis_bram_reader

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, giving the output stream data width.
REQ-002 The block SHALL have parameter BRAM_DATA_WIDTH, default 32, giving the BRAM read data width; it equals AXIS_TDATA_WIDTH.
REQ-003 The block SHALL have parameter BRAM_ADDR_WIDTH, default 10, giving the BRAM word address width.
REQ-004 The block SHALL have parameter CONTINUOUS, default "FALSE"; when "TRUE", passes repeat until a stop request.
REQ-005 The block SHALL have the following ports:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_data  in  BRAM_ADDR_WIDTH  last word address L of a pass (pass length L+1).
- cfg_start  in  1  start request, sampled only in IDLE.
- cfg_stop  in  1  stop request for continuous mode.
- sts_busy  out  1  high in every state except IDLE.
- sts_data  out  BRAM_ADDR_WIDTH  count of words accepted downstream in the current pass.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks word L of each pass.
- bram_portb_clk  out  1  equals aclk.
- bram_portb_rst  out  1  equals areset.
- bram_portb_addr  out  BRAM_ADDR_WIDTH  read word address.
- bram_portb_rddata  in  BRAM_DATA_WIDTH  read data, valid one clock after the address.

Function
REQ-006 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-007 IDLE -> RUN SHALL occur on the clock edge where cfg_start=1; L is latched from cfg_data on that edge, and read address 0 is issued.
REQ-008 cfg_data changes after the latch, and cfg_start outside IDLE, SHALL be ignored.
REQ-009 The first word (address 0) SHALL be presented with m_axis_tvalid=1 no later than the second clock edge after start acceptance.
REQ-010 A word SHALL transfer only on an edge where tvalid=1 and tready=1.
- Once tvalid is asserted, tdata, tvalid and tlast SHALL hold stable until the transfer completes.
REQ-011 With tready held high, the block SHALL sustain one word per clock with no bubbles, including across the continuous-mode wrap from L to 0.
REQ-012 Under arbitrary tready backpressure, every address 0..L SHALL be delivered exactly once per pass, in order.
- A two-entry skid buffer absorbs the one-cycle BRAM read latency.
REQ-013 m_axis_tlast SHALL be 1 exactly on the word read from address L.
REQ-014 In one-shot mode, issuing address L SHALL move the FSM RUN -> DRAIN.
- DRAIN -> IDLE SHALL occur on the edge where the tlast word transfers.
REQ-015 In continuous mode, the read address after L SHALL wrap to 0.
- cfg_stop=1 in RUN sets a sticky stop flag; the current pass completes through tlast, then the FSM goes to IDLE.
- No word of the next pass is presented after that tlast.
REQ-016 sts_data SHALL increment on each transfer and clear to 0 on the tlast transfer and on start acceptance.
REQ-017 L=0 SHALL produce single-word passes, each with tlast=1.
REQ-018 L=2^BRAM_ADDR_WIDTH-1 SHALL read the full memory with natural address wrap.
REQ-019 cfg_start and cfg_stop high on the same IDLE edge SHALL start a pass with the stop flag set, so exactly one pass is produced.

Reset
REQ-020 areset=1 SHALL asynchronously force the following, regardless of any transfer in progress:
- FSM to IDLE;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- sts_busy=0, sts_data=0, bram_portb_addr=0;
- skid buffer empty, stop flag clear.
REQ-021 After areset deasserts, no stream output SHALL occur until a new cfg_start is accepted.

Structure
REQ-022 No shared package SHALL be used; the FSM state encodings are local constants.
REQ-023 The skid buffer SHALL be a sub-module named axis_skid_buffer: two entries, data plus last, with valid/ready on both sides.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- BRAM[i]=i+100, L=7, one-shot, tready=1 -> words 100..107 on 8 consecutive edges, tlast only on 107, sts_busy falls after the last transfer.
- Same setup, tready toggling 1,0,0,1 repeatedly -> 100..107 each exactly once, tdata stable while stalled.
- CONTINUOUS="TRUE", L=3, tready=1, cfg_stop pulsed during the 2nd pass -> 100..103 twice with no gap at the wrap, tlast after each 103, then IDLE.
- L=0 one-shot -> a single word 100 with tlast=1.
- areset asserted while tvalid=1 mid-pass -> tvalid=0 with no clock edge required; the next start (L=2) yields 100,101,102.
- cfg_start pulsed during RUN -> ignored; the sequence is unchanged.
